gemm_stream_engine: RTL

//  Parametrised memory-mapped matrix multiply engine: C = A*B, or C += A*B in accumulate mode.

---
 rtl/gemm_pkg.sv | 29 ++
 rtl/gemm_addr_gen.sv | 40 ++++
 rtl/gemm_stream_engine.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM stream engine: FSM encoding, header layout, bus encodings.
package gemm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HDR   = 4'd1,
        ST_CHECK = 4'd2,
        ST_CELL  = 4'd3,
        ST_RD_C  = 4'd4,
        ST_RD_A  = 4'd5,
        ST_RD_B  = 4'd6,
        ST_MAC   = 4'd7,
        ST_WR_C  = 4'd8,
        ST_DONE  = 4'd9,
        ST_ERR   = 4'd10
    } state_e;

    // Word offsets of the dimension header relative to cfg_base
    localparam int unsigned HDR_WIDTH_A  = 0;
    localparam int unsigned HDR_HEIGHT_A = 1;
    localparam int unsigned HDR_WIDTH_B  = 2;
    localparam int unsigned HDR_HEIGHT_B = 3;
    localparam int unsigned HDR_LEN      = 4;

    // mem_we encodings
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/gemm_addr_gen.sv
// Combinational address generator: operand region bases and the word address for the current state.
import gemm_pkg::*;

module gemm_addr_gen #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 16
) (
    input  state_e              state,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [1:0]          hdr_idx,
    input  logic [DIM_W-1:0]    width_a,
    input  logic [DIM_W-1:0]    height_a,
    input  logic [DIM_W-1:0]    width_b,
    input  logic [DIM_W-1:0]    height_b,
    input  logic [DIM_W-1:0]    i,
    input  logic [DIM_W-1:0]    j,
    input  logic [DIM_W-1:0]    k,
    output logic [ADDR_W-1:0]   addr
);

    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_c;

    // Region bases follow the header; every term is widened to ADDR_W so products wrap mod 2^ADDR_W
    always_comb begin
        base_a = cfg_base + ADDR_W'(HDR_LEN);
        base_b = base_a + ADDR_W'(height_a) * ADDR_W'(width_a);
        base_c = base_b + ADDR_W'(height_b) * ADDR_W'(width_b);
        addr   = '0;
        case (state)
            ST_HDR:           addr = cfg_base + ADDR_W'(hdr_idx);
            ST_RD_A:          addr = base_a + ADDR_W'(i) * ADDR_W'(width_a) + ADDR_W'(k);
            ST_RD_B:          addr = base_b + ADDR_W'(k) * ADDR_W'(width_b) + ADDR_W'(j);
            ST_RD_C, ST_WR_C: addr = base_c + ADDR_W'(i) * ADDR_W'(width_b) + ADDR_W'(j);
            default:          addr = '0;
        endcase
    end

endmodule

// File: rtl/gemm_stream_engine.sv
// Memory-mapped GEMM engine: C = A*B or C += A*B over a single-outstanding word bus.
// Optional macro GEMM_SATURATE_EN: clamp results to the signed DATA_W range instead of truncating.
import gemm_pkg::*;

module gemm_stream_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                acc_mode,
    input  logic [ADDR_W-1:0]   cfg_base,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    state_e                     state_q, state_n;
    logic                       acc_mode_q, acc_mode_n;
    logic [ADDR_W-1:0]          base_q, base_n;
    logic [1:0]                 hdr_idx_q, hdr_idx_n;
    logic [DIM_W-1:0]           width_a_q, width_a_n;
    logic [DIM_W-1:0]           height_a_q, height_a_n;
    logic [DIM_W-1:0]           width_b_q, width_b_n;
    logic [DIM_W-1:0]           height_b_q, height_b_n;
    logic [DIM_W-1:0]           i_q, i_n;
    logic [DIM_W-1:0]           j_q, j_n;
    logic [DIM_W-1:0]           k_q, k_n;
    logic [ACC_W-1:0]           acc_q, acc_n;
    logic signed [DATA_W-1:0]   opa_q, opa_n;
    logic signed [DATA_W-1:0]   opb_q, opb_n;

    logic                       busy_n, done_n, err_n;
    logic                       mem_req_n, mem_we_n;
    logic [ADDR_W-1:0]          mem_addr_n;
    logic [DATA_W-1:0]          mem_wdata_n;

    logic [ADDR_W-1:0]          addr_c;
    logic [DATA_W-1:0]          wdata_c;
    logic signed [2*DATA_W-1:0] prod_c;
    logic                       ack_c;
    logic                       req_state_c;
    logic [DIM_W-1:0]           k_inc_c;

    gemm_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .state    (state_q),
        .cfg_base (base_q),
        .hdr_idx  (hdr_idx_q),
        .width_a  (width_a_q),
        .height_a (height_a_q),
        .width_b  (width_b_q),
        .height_b (height_b_q),
        .i        (i_q),
        .j        (j_q),
        .k        (k_q),
        .addr     (addr_c)
    );

    assign prod_c = opa_q * opb_q;

`ifdef GEMM_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Clamp the accumulator into the signed element range
    always_comb begin
        if ($signed(acc_q) > SAT_MAX) begin
            wdata_c = {1'b0, {(DATA_W-1){1'b1}}};
        end else if ($signed(acc_q) < SAT_MIN) begin
            wdata_c = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            wdata_c = acc_q[DATA_W-1:0];
        end
    end
`else
    // Truncate the accumulator to the element width
    always_comb begin
        wdata_c = acc_q[DATA_W-1:0];
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_mode_q <= 1'b0;
            base_q     <= '0;
            hdr_idx_q  <= '0;
            width_a_q  <= '0;
            height_a_q <= '0;
            width_b_q  <= '0;
            height_b_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_n;
            acc_mode_q <= acc_mode_n;
            base_q     <= base_n;
            hdr_idx_q  <= hdr_idx_n;
            width_a_q  <= width_a_n;
            height_a_q <= height_a_n;
            width_b_q  <= width_b_n;
            height_b_q <= height_b_n;
            i_q        <= i_n;
            j_q        <= j_n;
            k_q        <= k_n;
            acc_q      <= acc_n;
            opa_q      <= opa_n;
            opb_q      <= opb_n;
            busy       <= busy_n;
            done       <= done_n;
            err        <= err_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
        end
    end

    // Next-state, bus handshake and MAC datapath
    always_comb begin
        state_n     = state_q;
        acc_mode_n  = acc_mode_q;
        base_n      = base_q;
        hdr_idx_n   = hdr_idx_q;
        width_a_n   = width_a_q;
        height_a_n  = height_a_q;
        width_b_n   = width_b_q;
        height_b_n  = height_b_q;
        i_n         = i_q;
        j_n         = j_q;
        k_n         = k_q;
        acc_n       = acc_q;
        opa_n       = opa_q;
        opb_n       = opb_q;
        busy_n      = busy;
        done_n      = 1'b0;
        err_n       = 1'b0;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        k_inc_c     = k_q + DIM_W'(1);

        ack_c       = mem_req && mem_ack;
        req_state_c = (state_q == ST_HDR)  || (state_q == ST_RD_C) || (state_q == ST_RD_A) ||
                      (state_q == ST_RD_B) || (state_q == ST_WR_C);

        // A request is launched only while the bus is idle, which guarantees the gap cycle after an ack
        if (req_state_c && !mem_req) begin
            mem_req_n   = 1'b1;
            mem_we_n    = (state_q == ST_WR_C) ? MEM_WR : MEM_RD;
            mem_addr_n  = addr_c;
            mem_wdata_n = wdata_c;
        end
        if (ack_c) begin
            mem_req_n = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n    = ST_HDR;
                    busy_n     = 1'b1;
                    acc_mode_n = acc_mode;
                    base_n     = cfg_base;
                    hdr_idx_n  = '0;
                end
            end
            ST_HDR: begin
                if (ack_c) begin
                    case (hdr_idx_q)
                        2'(HDR_WIDTH_A):  width_a_n  = DIM_W'(mem_rdata);
                        2'(HDR_HEIGHT_A): height_a_n = DIM_W'(mem_rdata);
                        2'(HDR_WIDTH_B):  width_b_n  = DIM_W'(mem_rdata);
                        default:          height_b_n = DIM_W'(mem_rdata);
                    endcase
                    if (hdr_idx_q == 2'(HDR_LEN - 1)) begin
                        state_n = ST_CHECK;
                    end else begin
                        hdr_idx_n = hdr_idx_q + 2'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (width_a_q != height_b_q) begin
                    state_n = ST_ERR;
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                end else if ((width_a_q == '0) || (height_a_q == '0) ||
                             (width_b_q == '0) || (height_b_q == '0)) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    i_n     = '0;
                    j_n     = '0;
                    state_n = ST_CELL;
                end
            end
            ST_CELL: begin
                acc_n   = '0;
                k_n     = '0;
                state_n = acc_mode_q ? ST_RD_C : ST_RD_A;
            end
            ST_RD_C: begin
                if (ack_c) begin
                    acc_n   = ACC_W'($signed(mem_rdata));
                    state_n = ST_RD_A;
                end
            end
            ST_RD_A: begin
                if (ack_c) begin
                    opa_n   = mem_rdata;
                    state_n = ST_RD_B;
                end
            end
            ST_RD_B: begin
                if (ack_c) begin
                    opb_n   = mem_rdata;
                    state_n = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_n   = acc_q + ACC_W'(prod_c);
                k_n     = k_inc_c;
                state_n = (k_inc_c == width_a_q) ? ST_WR_C : ST_RD_A;
            end
            ST_WR_C: begin
                if (ack_c) begin
                    if ((j_q + DIM_W'(1)) == width_b_q) begin
                        j_n = '0;
                        if ((i_q + DIM_W'(1)) == height_a_q) begin
                            state_n = ST_DONE;
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                        end else begin
                            i_n     = i_q + DIM_W'(1);
                            state_n = ST_CELL;
                        end
                    end else begin
                        j_n     = j_q + DIM_W'(1);
                        state_n = ST_CELL;
                    end
                end
            end
            ST_DONE:  state_n = ST_IDLE;
            ST_ERR:   state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

endmodule
